// File: rtl/br_pkg.sv
// rtl/br_pkg.sv - shared types and constants for the branch resolve unit
package br_pkg;

    localparam int BHT_DEPTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_state_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Only 010 and 011 fall outside the conditional-branch encodings.
    function automatic logic f3_legal(input logic [2:0] f3);
        return f3[2:1] != 2'b01;
    endfunction

endpackage

// File: rtl/sat_cnt2.sv
// rtl/sat_cnt2.sv - 2-bit saturating predictor counter, resets to weakly-not-taken
module sat_cnt2
    import br_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_en,
    input  logic       i_up,
    output cnt_state_e o_state
);

    cnt_state_e state_q;
    cnt_state_e state_d;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= WNT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (i_en) begin
            case (state_q)
                SNT:     state_d = i_up ? WNT : SNT;
                WNT:     state_d = i_up ? WT  : SNT;
                WT:      state_d = i_up ? ST  : WNT;
                ST:      state_d = i_up ? ST  : WT;
                default: state_d = WNT;
            endcase
        end
    end

    assign o_state = state_q;

endmodule

// File: rtl/br_resolve.sv
// rtl/br_resolve.sv - branch outcome resolution, BHT prediction and statistics counters
module br_resolve
    import br_pkg::*;
#(
    parameter int BHT_DEPTH = BHT_DEPTH_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_pc,
    output logic        o_pred_taken,
    input  logic        i_ex_valid,
    input  logic [31:0] i_ex_pc,
    input  logic [2:0]  i_ex_funct3,
    input  logic        i_ex_pred_taken,
    output logic        o_br_un,
    input  logic        i_br_less,
    input  logic        i_br_equal,
    output logic        o_taken,
    output logic        o_mispredict,
    output logic        o_illegal,
    output logic [31:0] o_branch_cnt,
    output logic [31:0] o_mispred_cnt
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] up_idx;
    cnt_state_e       bht [BHT_DEPTH];
    logic [1:0]       lk_state;

    logic        active;
    logic        legal;
    logic        taken_raw;
    logic        upd_en;
    logic        mispred_en;
    logic [31:0] branch_cnt_q, branch_cnt_d;
    logic [31:0] mispred_cnt_q, mispred_cnt_d;
    logic        unused_pc_bits;

    assign lk_idx         = i_pc[IDX_W+1:2];
    assign up_idx         = i_ex_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{i_pc[31:IDX_W+2], i_pc[1:0], i_ex_pc[31:IDX_W+2], i_ex_pc[1:0]};

    always_comb begin
        taken_raw = 1'b0;
        case (i_ex_funct3)
            F3_BEQ:          taken_raw = i_br_equal;
            F3_BNE:          taken_raw = !i_br_equal;
            F3_BLT, F3_BLTU: taken_raw = i_br_less;
            F3_BGE, F3_BGEU: taken_raw = !i_br_less;
            default:         taken_raw = 1'b0;
        endcase

        // A branch resolving under reset is dropped entirely.
        active        = i_ex_valid && !i_reset;
        legal         = f3_legal(i_ex_funct3);
        upd_en        = active && legal;
        mispred_en    = upd_en && (taken_raw ^ i_ex_pred_taken);
        o_taken       = upd_en && taken_raw;
        o_mispredict  = mispred_en;
        o_illegal     = active && !legal;
        o_br_un       = i_ex_funct3[1];
        branch_cnt_d  = branch_cnt_q + {31'b0, upd_en};
        mispred_cnt_d = mispred_cnt_q + {31'b0, mispred_en};
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            branch_cnt_q  <= 32'd0;
            mispred_cnt_q <= 32'd0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    for (genvar g = 0; g < BHT_DEPTH; g++) begin : g_bht
        sat_cnt2 u_cnt (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_en    (upd_en && (up_idx == IDX_W'(g))),
            .i_up    (taken_raw),
            .o_state (bht[g])
        );
    end

    // Lookup reads the registered state, so a same-cycle update shows up one cycle later.
    assign lk_state      = bht[lk_idx];
    assign o_pred_taken  = lk_state[1];
    assign o_branch_cnt  = branch_cnt_q;
    assign o_mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_br_resolve.sv
// tb/tb_br_resolve.sv - randomized self-checking bench for br_resolve
module tb_br_resolve;

    localparam int DEPTH = 16;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [31:0] i_pc;
    logic        o_pred_taken;
    logic        i_ex_valid;
    logic [31:0] i_ex_pc;
    logic [2:0]  i_ex_funct3;
    logic        i_ex_pred_taken;
    logic        o_br_un;
    logic        i_br_less;
    logic        i_br_equal;
    logic        o_taken;
    logic        o_mispredict;
    logic        o_illegal;
    logic [31:0] o_branch_cnt;
    logic [31:0] o_mispred_cnt;

    int          n_tests = 0;
    int          n_fail  = 0;

    int          m_cnt [DEPTH];
    logic [31:0] m_br;
    logic [31:0] m_mp;

    br_resolve #(.BHT_DEPTH(DEPTH)) dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_pc            (i_pc),
        .o_pred_taken    (o_pred_taken),
        .i_ex_valid      (i_ex_valid),
        .i_ex_pc         (i_ex_pc),
        .i_ex_funct3     (i_ex_funct3),
        .i_ex_pred_taken (i_ex_pred_taken),
        .o_br_un         (o_br_un),
        .i_br_less       (i_br_less),
        .i_br_equal      (i_br_equal),
        .o_taken         (o_taken),
        .o_mispredict    (o_mispredict),
        .o_illegal       (o_illegal),
        .o_branch_cnt    (o_branch_cnt),
        .o_mispred_cnt   (o_mispred_cnt)
    );

    always #5 i_clk = ~i_clk;

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc >> 2) % DEPTH);
    endfunction

    function automatic logic m_legal(input logic [2:0] f3);
        return !(f3 == 3'd2 || f3 == 3'd3);
    endfunction

    function automatic logic m_taken(input logic [2:0] f3, input logic less, input logic eq);
        if (f3 == 3'd0) return eq;
        if (f3 == 3'd1) return !eq;
        if (f3 == 3'd4 || f3 == 3'd6) return less;
        if (f3 == 3'd5 || f3 == 3'd7) return !less;
        return 1'b0;
    endfunction

    function automatic logic m_pred(input logic [31:0] pc);
        return m_cnt[m_idx(pc)] >= 2;
    endfunction

    task automatic drive(input logic v, input logic [31:0] pc, input logic [2:0] f3,
                         input logic less, input logic eq, input logic pred);
        i_ex_valid      = v;
        i_ex_pc         = pc;
        i_ex_funct3     = f3;
        i_br_less       = less;
        i_br_equal      = eq;
        i_ex_pred_taken = pred;
    endtask

    // Commit the model with the inputs present at the coming edge, then advance past it.
    task automatic tick();
        logic t;
        int   k;
        if (i_reset) begin
            for (int j = 0; j < DEPTH; j++) m_cnt[j] = 1;
            m_br = 0;
            m_mp = 0;
        end else if (i_ex_valid && m_legal(i_ex_funct3)) begin
            t = m_taken(i_ex_funct3, i_br_less, i_br_equal);
            k = m_idx(i_ex_pc);
            if (t) m_cnt[k] = (m_cnt[k] == 3) ? 3 : m_cnt[k] + 1;
            else   m_cnt[k] = (m_cnt[k] == 0) ? 0 : m_cnt[k] - 1;
            m_br = m_br + 1;
            if (t != i_ex_pred_taken) m_mp = m_mp + 1;
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic apply_reset();
        i_reset = 1'b1;
        drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        tick();
        i_reset = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        i_pc    = 32'h40;
        drive(1'b1, 32'h40, 3'd0, 1'b0, 1'b1, 1'b0);
        #1;
        n_tests++;
        if ({o_taken, o_mispredict, o_illegal} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_outs: got %b expected 000", {o_taken, o_mispredict, o_illegal});
        end
        tick();
        i_reset = 1'b0;
        drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        #1;
        n_tests++;
        if (o_pred_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pred: got %b expected 0", o_pred_taken);
        end
        n_tests++;
        if (o_branch_cnt !== 32'd0 || o_mispred_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_counts: got %0h/%0h expected 0/0", o_branch_cnt, o_mispred_cnt);
        end
    endtask

    task automatic test_blt_mispredict();
        i_pc = 32'h40;
        drive(1'b1, 32'h40, 3'b100, 1'b1, 1'b0, 1'b0);
        #1;
        n_tests++;
        if (o_taken !== 1'b1 || o_mispredict !== 1'b1) begin
            n_fail++;
            $display("FAIL blt_outcome: got taken=%b mis=%b expected 1 1", o_taken, o_mispredict);
        end
        tick();
        drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        #1;
        n_tests++;
        if (o_pred_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL blt_pred: got %b expected 1", o_pred_taken);
        end
        n_tests++;
        if (o_branch_cnt !== 32'd1 || o_mispred_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL blt_counts: got %0d/%0d expected 1/1", o_branch_cnt, o_mispred_cnt);
        end
    endtask

    task automatic test_counter_path();
        int   path [7] = '{1, 2, 3, 3, 3, 2, 1};
        logic outc [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        apply_reset();
        i_pc = 32'h80;
        for (int s = 0; s < 7; s++) begin
            if (s < 6) drive(1'b1, 32'h80, 3'b000, 1'b0, outc[s], m_pred(32'h80));
            else       drive(1'b0, 32'h80, 3'b000, 1'b0, 1'b0, 1'b0);
            #1;
            n_tests++;
            if (o_pred_taken !== (path[s] >= 2) || m_cnt[m_idx(32'h80)] != path[s]) begin
                n_fail++;
                $display("FAIL counter_path[%0d]: got pred=%b expected %b", s, o_pred_taken, path[s] >= 2);
            end
            if (s < 6) tick();
        end
    endtask

    task automatic test_bgeu_illegal();
        logic [31:0] br0, mp0;
        drive(1'b1, 32'h44, 3'b111, 1'b0, 1'b0, 1'b0);
        #1;
        n_tests++;
        if (o_br_un !== 1'b1 || o_taken !== 1'b1 || o_mispredict !== 1'b1) begin
            n_fail++;
            $display("FAIL bgeu: got un=%b taken=%b mis=%b expected 1 1 1", o_br_un, o_taken, o_mispredict);
        end
        tick();
        br0 = m_br;
        mp0 = m_mp;
        i_pc = 32'h48;
        drive(1'b1, 32'h48, 3'b011, 1'b1, 1'b1, 1'b0);
        #1;
        n_tests++;
        if (o_illegal !== 1'b1 || o_taken !== 1'b0 || o_mispredict !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_flags: got ill=%b taken=%b mis=%b expected 1 0 0", o_illegal, o_taken, o_mispredict);
        end
        tick();
        drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        #1;
        n_tests++;
        if (o_branch_cnt !== br0 || o_mispred_cnt !== mp0 || o_pred_taken !== m_pred(32'h48)) begin
            n_fail++;
            $display("FAIL illegal_nochange: got %0d/%0d pred=%b expected %0d/%0d pred=%b",
                     o_branch_cnt, o_mispred_cnt, o_pred_taken, br0, mp0, m_pred(32'h48));
        end
    endtask

    task automatic test_same_cycle_alias();
        apply_reset();
        i_pc = 32'h100;
        drive(1'b1, 32'h100, 3'b000, 1'b0, 1'b1, 1'b0);
        #1;
        n_tests++;
        if (o_pred_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL same_cycle_old: got %b expected 0", o_pred_taken);
        end
        tick();
        drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        #1;
        n_tests++;
        if (o_pred_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL same_cycle_new: got %b expected 1", o_pred_taken);
        end
        i_pc = 32'h140;
        #1;
        n_tests++;
        if (o_pred_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL alias_lookup: got %b expected 1", o_pred_taken);
        end
        i_pc = 32'h100;
        drive(1'b1, 32'h140, 3'b001, 1'b0, 1'b1, 1'b1);
        #1;
        n_tests++;
        if (o_pred_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL alias_old: got %b expected 1", o_pred_taken);
        end
        tick();
        drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        #1;
        n_tests++;
        if (o_pred_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL alias_new: got %b expected 0", o_pred_taken);
        end
    endtask

    task automatic test_random();
        logic lg, tk;
        for (int n = 0; n < 400; n++) begin
            i_reset = ($urandom_range(0, 39) == 0);
            i_pc    = $urandom;
            drive($urandom_range(0, 3) != 0, {24'h0, 8'($urandom_range(0, 255))},
                  3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom));
            #1;
            lg = i_ex_valid && !i_reset && m_legal(i_ex_funct3);
            tk = lg && m_taken(i_ex_funct3, i_br_less, i_br_equal);
            n_tests++;
            if (o_taken !== tk || o_mispredict !== (lg && (tk != i_ex_pred_taken))) begin
                n_fail++;
                $display("FAIL rand_outcome[%0d]: got taken=%b mis=%b expected %b %b",
                         n, o_taken, o_mispredict, tk, lg && (tk != i_ex_pred_taken));
            end
            n_tests++;
            if (o_illegal !== (i_ex_valid && !i_reset && !m_legal(i_ex_funct3)) || o_br_un !== i_ex_funct3[1]) begin
                n_fail++;
                $display("FAIL rand_flags[%0d]: got ill=%b un=%b", n, o_illegal, o_br_un);
            end
            n_tests++;
            if (o_pred_taken !== m_pred(i_pc)) begin
                n_fail++;
                $display("FAIL rand_pred[%0d]: got %b expected %b", n, o_pred_taken, m_pred(i_pc));
            end
            n_tests++;
            if (o_branch_cnt !== m_br || o_mispred_cnt !== m_mp) begin
                n_fail++;
                $display("FAIL rand_counts[%0d]: got %0d/%0d expected %0d/%0d", n, o_branch_cnt, o_mispred_cnt, m_br, m_mp);
            end
            tick();
        end
        i_reset = 1'b0;
    endtask

    task automatic test_wrap();
        force dut.branch_cnt_q  = 32'hFFFF_FFFE;
        force dut.mispred_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.branch_cnt_q;
        release dut.mispred_cnt_q;
        m_br = 32'hFFFF_FFFE;
        m_mp = 32'hFFFF_FFFF;
        drive(1'b1, 32'h10, 3'b100, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        #1;
        n_tests++;
        if (o_branch_cnt !== 32'hFFFF_FFFF || o_mispred_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL wrap_first: got %0h/%0h expected ffffffff/0", o_branch_cnt, o_mispred_cnt);
        end
        drive(1'b1, 32'h14, 3'b000, 1'b0, 1'b1, 1'b1);
        tick();
        drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        #1;
        n_tests++;
        if (o_branch_cnt !== 32'd0 || o_mispred_cnt !== 32'd0 || m_br !== 32'd0) begin
            n_fail++;
            $display("FAIL wrap_zero: got %0h/%0h expected 0/0", o_branch_cnt, o_mispred_cnt);
        end
    endtask

    task automatic test_mid_reset();
        for (int n = 0; n < 20; n++) begin
            drive(1'b1, 32'($urandom_range(0, 63)) << 2, 3'b000, 1'b0, 1'b1, 1'b0);
            tick();
        end
        i_reset = 1'b1;
        drive(1'b1, 32'h20, 3'b000, 1'b0, 1'b1, 1'b0);
        #1;
        n_tests++;
        if ({o_taken, o_mispredict, o_illegal} !== 3'b000) begin
            n_fail++;
            $display("FAIL midreset_outs: got %b expected 000", {o_taken, o_mispredict, o_illegal});
        end
        tick();
        i_reset = 1'b0;
        drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < DEPTH; k++) begin
            i_pc = 32'(k) << 2;
            #1;
            n_tests++;
            if (o_pred_taken !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset_pred[%0d]: got %b expected 0", k, o_pred_taken);
            end
        end
        n_tests++;
        if (o_branch_cnt !== 32'd0 || o_mispred_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL midreset_counts: got %0d/%0d expected 0/0", o_branch_cnt, o_mispred_cnt);
        end
    endtask

    initial begin
        for (int j = 0; j < DEPTH; j++) m_cnt[j] = 1;
        m_br    = 0;
        m_mp    = 0;
        i_reset = 1'b1;
        i_pc    = 32'h0;
        drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        @(posedge i_clk);
        #1;
        test_reset();
        test_blt_mispredict();
        test_counter_path();
        test_bgeu_illegal();
        test_same_cycle_alias();
        test_random();
        test_wrap();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
